// File: rtl/hh_step_scheduler.sv
// Timestep scheduler that walks every neuron slot through a shared HH update engine once per tick.
// Optional: define HH_SCHED_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module hh_step_scheduler #(
   parameter int NUM_NEURONS = 4,
   parameter int IDX_W       = 2,
   parameter int TICK_DIV    = 64,
   parameter int TIMEOUT     = 15
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   run,
   input  logic                   clr_err,
   output logic                   eng_start,
   output logic [IDX_W-1:0]       eng_idx,
   input  logic                   eng_done,
   input  logic                   eng_spike,
   output logic [NUM_NEURONS-1:0] spike_vec,
   output logic                   step_done,
   output logic                   busy,
   output logic                   overrun,
   output logic                   timeout_err
`ifdef HH_SCHED_OVERRUN_CNT_EN
   ,
   output logic [7:0]             overrun_cnt
`endif
);

   localparam int PRE_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_NEURONS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_COMMIT
   } state_t;

   state_t                  state_reg, state_next;
   logic [PRE_W-1:0]        presc_reg, presc_next;
   logic [IDX_W-1:0]        idx_reg, idx_next;
   logic [WAIT_W-1:0]       wait_reg, wait_next;
   logic [NUM_NEURONS-1:0]  shadow_reg, shadow_next;
   logic [NUM_NEURONS-1:0]  spike_vec_reg;
   logic                    overrun_reg, timeout_err_reg;
   logic                    tick;
   logic                    slot_wr, slot_bit, timeout_set, overrun_set;

   // Prescaler only advances while run is high; it parks at zero otherwise.
   assign tick = run && (presc_reg == PRE_LAST);

   always_comb begin
      presc_next = presc_reg;
      if (!run || presc_reg == PRE_LAST) begin
         presc_next = '0;
      end else begin
         presc_next = presc_reg + 1'b1;
      end
   end

   always_comb begin
      state_next  = state_reg;
      idx_next    = idx_reg;
      wait_next   = wait_reg;
      slot_wr     = 1'b0;
      slot_bit    = 1'b0;
      timeout_set = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (tick) begin
               idx_next   = '0;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            wait_next  = '0;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            // A done in the last allowed WAIT cycle still counts as a real answer.
            if (eng_done) begin
               slot_wr  = 1'b1;
               slot_bit = eng_spike;
            end else if (wait_reg == WAIT_LAST) begin
               slot_wr     = 1'b1;
               timeout_set = 1'b1;
            end else begin
               wait_next = wait_reg + 1'b1;
            end
            if (slot_wr) begin
               if (idx_reg == IDX_LAST) begin
                  state_next = ST_COMMIT;
               end else begin
                  idx_next   = idx_reg + 1'b1;
                  state_next = ST_ISSUE;
               end
            end
         end
         ST_COMMIT: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_shadow
         assign shadow_next[gi] = (state_reg == ST_COMMIT) ? 1'b0 :
                                  (slot_wr && idx_reg == IDX_W'(gi)) ? slot_bit :
                                  shadow_reg[gi];
      end
   endgenerate

   assign overrun_set = tick && (state_reg != ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         presc_reg       <= '0;
         idx_reg         <= '0;
         wait_reg        <= '0;
         shadow_reg      <= '0;
         spike_vec_reg   <= '0;
         overrun_reg     <= 1'b0;
         timeout_err_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         presc_reg  <= presc_next;
         idx_reg    <= idx_next;
         wait_reg   <= wait_next;
         shadow_reg <= shadow_next;
         if (state_reg == ST_COMMIT) begin
            spike_vec_reg <= shadow_reg;
         end
         if (overrun_set) begin
            overrun_reg <= 1'b1;
         end else if (clr_err) begin
            overrun_reg <= 1'b0;
         end
         if (timeout_set) begin
            timeout_err_reg <= 1'b1;
         end else if (clr_err) begin
            timeout_err_reg <= 1'b0;
         end
      end
   end

`ifdef HH_SCHED_OVERRUN_CNT_EN
   logic [7:0] overrun_cnt_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overrun_cnt_reg <= '0;
      end else if (overrun_set) begin
         if (overrun_cnt_reg != 8'hFF) begin
            overrun_cnt_reg <= overrun_cnt_reg + 1'b1;
         end
      end else if (clr_err) begin
         overrun_cnt_reg <= '0;
      end
   end

   assign overrun_cnt = overrun_cnt_reg;
`else
   // Default build carries no dropped-tick counter.
`endif

   assign eng_start   = (state_reg == ST_ISSUE);
   assign eng_idx     = idx_reg;
   assign step_done   = (state_reg == ST_COMMIT);
   assign busy        = (state_reg != ST_IDLE);
   assign spike_vec   = spike_vec_reg;
   assign overrun     = overrun_reg;
   assign timeout_err = timeout_err_reg;

endmodule

// File: doc/hh_step_scheduler.md
HH_STEP_SCHEDULER -- requirements
Module: hh_step_scheduler

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 4: number of neuron state slots served per timestep (2..16).
REQ-002 SHALL have parameter IDX_W, default 2: neuron index width, with 2^IDX_W >= NUM_NEURONS.
REQ-003 SHALL have parameter TICK_DIV, default 64: clock cycles per timestep tick (>= 2).
REQ-004 SHALL have parameter TIMEOUT, default 15: maximum WAIT cycles per neuron before forced completion.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-007 SHALL have port run  input  1  enables the timestep prescaler.
REQ-008 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-009 SHALL have port eng_start  output  1  one-cycle request to the shared HH update engine.
REQ-010 SHALL have port eng_idx  output  IDX_W  neuron slot the engine updates; valid while eng_start is high and throughout WAIT.
REQ-011 SHALL have port eng_done  input  1  engine completion strobe.
REQ-012 SHALL have port eng_spike  input  1  spike result from the engine; qualified by eng_done.
REQ-013 SHALL have port spike_vec  output  NUM_NEURONS  spike flags of the last committed timestep; bit i = neuron i.
REQ-014 SHALL have port step_done  output  1  one-cycle pulse on commit.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port overrun  output  1  sticky: a tick arrived while busy.
REQ-017 SHALL have port timeout_err  output  1  sticky: engine failed to respond within TIMEOUT.

Function
REQ-018 SHALL count the prescaler 0..TICK_DIV-1 while run=1, wrapping to 0; while run=0 SHALL hold it at 0; tick is internal and high in the cycle the count equals TICK_DIV-1.
REQ-019 SHALL implement the FSM IDLE, ISSUE, WAIT, COMMIT, with outputs decoded from registered state (Moore).
REQ-020 IDLE: on tick, SHALL load idx=0 and move to ISSUE; eng_start therefore rises the cycle after tick.
REQ-021 ISSUE: SHALL drive eng_start=1 and eng_idx=idx for exactly one cycle, clear the wait counter, and move to WAIT; eng_done during ISSUE SHALL be ignored.
REQ-022 WAIT: on eng_done=1, SHALL write eng_spike into shadow bit idx; if idx=NUM_NEURONS-1, move to COMMIT, else increment idx and move to ISSUE.
REQ-023 WAIT: if the wait counter reaches TIMEOUT with eng_done low, SHALL write 0 into shadow bit idx, set timeout_err, and advance exactly as in REQ-022.
REQ-024 COMMIT: SHALL copy shadow to spike_vec, assert step_done for one cycle, clear shadow, and return to IDLE.
REQ-025 spike_vec SHALL change only in COMMIT; partial results are never visible.
REQ-026 A tick in any non-IDLE state SHALL set overrun and be dropped (not queued); the current step continues unaffected.
REQ-027 clr_err=1 SHALL clear overrun and timeout_err; when a set condition occurs in the same cycle, set SHALL win.
REQ-028 Deasserting run mid-step SHALL let the step complete through COMMIT; no further ticks are generated.
REQ-029 Minimum step length SHALL be 2*NUM_NEURONS+1 cycles from eng_start of slot 0 to step_done inclusive.

Reset
REQ-030 With rst_n=0 at a clock edge: state=IDLE, prescaler=0, idx=0, wait counter=0, shadow=0, spike_vec=0, eng_start=0, eng_idx=0, step_done=0, overrun=0, timeout_err=0, overrun_cnt=0.
REQ-031 Reset mid-step SHALL abandon the step without asserting step_done and without altering spike_vec beyond clearing it to 0.

Configuration
REQ-032 With macro HH_SCHED_OVERRUN_CNT_EN defined, SHALL add output overrun_cnt (8 bits): increments on each dropped tick, saturates at 255, and is cleared by clr_err (increment wins on the same cycle); without it, the port and counter SHALL not exist and all other behaviour is identical.

Verification (NUM_NEURONS=4, TICK_DIV=16, TIMEOUT=8)
REQ-033 run=1, engine returns eng_done 1 cycle after each eng_start with spikes 1,0,1,1 -> eng_idx 0,1,2,3 in order; spike_vec=4'b1101; one step_done pulse; sequence repeats every 16 cycles.
REQ-034 Engine delays done 20 cycles per slot -> step exceeds 16 cycles, overrun=1 after next tick, no second step starts early; with HH_SCHED_OVERRUN_CNT_EN, overrun_cnt increments once per dropped tick.
REQ-035 Engine never answers slot 2 -> after 8 WAIT cycles, slot 3 is issued, spike_vec bit2=0, timeout_err=1; clr_err pulse -> timeout_err=0.
REQ-036 rst_n=0 while WAITing on slot 1 -> next cycle busy=0, spike_vec=0, no step_done; after release, the first eng_start occurs 16 cycles after run is seen.
REQ-037 run dropped during slot 1 -> slots 2,3 still issued, step_done pulses once, then busy stays 0 and no eng_start for 100 cycles.
